// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the bitonic sorter front end.
// Element width comes from the global DATA_WIDTH macro; 16 bits unless the build sets it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package bitonic_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [`DATA_WIDTH-1:0] pad_value();
        return '1;
    endfunction

    // Width of a count that must hold 1..n inclusive.
    function automatic int CNT_W(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/bitonic_in_packer_if.sv
// Serial element input and packed-frame output of the bitonic input packer.
// Handshake: a beat transfers on a rising edge where s_valid && s_ready; s_data/s_last are
// only meaningful with s_valid, and vec_valid is a one-cycle pulse with no backpressure.
interface bitonic_in_packer_if
    import bitonic_pkg::*;
#(
    parameter int N = 8
);
    logic                         s_valid;
    logic [`DATA_WIDTH-1:0]       s_data;
    logic                         s_last;
    logic                         s_ready;
    logic                         vec_valid;
    logic [N*`DATA_WIDTH-1:0]     vec_data;
    logic [CNT_W(N)-1:0]          vec_count;
    state_t                       dbg_state;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, vec_valid, vec_data, vec_count, dbg_state
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, vec_valid, vec_data, vec_count, dbg_state
    );
endinterface

// File: rtl/bitonic_in_packer.sv
// Packs a serial element stream into an N-wide frame, padding short frames with all-ones,
// and presents each completed frame to the sorting network as a single-cycle pulse.
module bitonic_in_packer
    import bitonic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitonic_in_packer_if.slave   bus
);
    localparam int DW    = `DATA_WIDTH;
    localparam int IDX_W = $clog2(N);
    localparam int CW    = CNT_W(N);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [DW-1:0]       slots [N];
    logic                vec_valid_q;
    logic [N*DW-1:0]     vec_data_q;
    logic [CW-1:0]       vec_count_q;

    logic                accept;
    logic                complete;
    logic [N-1:0]        wr_en;
    logic [N-1:0]        pad_en;
    logic [N*DW-1:0]     frame_next;

    // rst_n gating keeps ready low while reset is held even though state already reads FILL.
    assign bus.s_ready  = rst_n && (state == FILL);
    assign accept       = bus.s_valid && bus.s_ready;
    assign complete     = accept && ((idx == IDX_W'(N - 1)) || bus.s_last);

    // Slot decoder: the completing beat lands at idx, everything above it becomes PAD.
    always_comb begin
        wr_en      = '0;
        pad_en     = '0;
        frame_next = '0;
        for (int i = 0; i < N; i++) begin
            wr_en[i]  = accept && (idx == IDX_W'(i));
            pad_en[i] = complete && (IDX_W'(i) > idx);
            if (wr_en[i]) begin
                frame_next[i*DW +: DW] = bus.s_data;
            end else if (pad_en[i]) begin
                frame_next[i*DW +: DW] = pad_value();
            end else begin
                frame_next[i*DW +: DW] = slots[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    slots[i] <= bus.s_data;
                end
            end
        end
    end

    // Output frame is captured only on completion so vec_data stays stable between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= '0;
            vec_valid_q <= 1'b0;
            vec_data_q  <= '0;
            vec_count_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (complete) begin
                        state       <= EMIT;
                        vec_valid_q <= 1'b1;
                        vec_data_q  <= frame_next;
                        vec_count_q <= CW'(idx) + CW'(1);
                        idx         <= '0;
                    end else if (accept) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                EMIT: begin
                    state       <= FILL;
                    vec_valid_q <= 1'b0;
                end
                default: begin
                    state       <= FILL;
                    vec_valid_q <= 1'b0;
                    idx         <= '0;
                end
            endcase
        end
    end

    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_data  = vec_data_q;
    assign bus.vec_count = vec_count_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bitonic_in_packer.sv
// Self-checking bench for bitonic_in_packer with N=8 and 16-bit elements.
// Frames are predicted from accepted beats and matched against each vec_valid pulse.
module tb_bitonic_in_packer;
    import bitonic_pkg::*;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int CW = 4;

    logic clk;
    logic rst_n;

    bitonic_in_packer_if #(.N(N)) bus ();

    bitonic_in_packer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [N*DW-1:0] exp_q[$];
    logic [CW-1:0]   cnt_q[$];
    int              pulse_cyc[$];
    logic [DW-1:0]   mdl [N];
    int              mdl_idx;
    int              pulses;
    int              vectors;
    int              miscompares;

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        logic [N*DW-1:0] f;
        mdl[mdl_idx] = d;
        if (mdl_idx == N - 1 || l) begin
            for (int i = 0; i < N; i++) begin
                f[i*DW +: DW] = (i <= mdl_idx) ? mdl[i] : 16'hFFFF;
            end
            exp_q.push_back(f);
            cnt_q.push_back(CW'(mdl_idx + 1));
            mdl_idx = 0;
        end else begin
            mdl_idx++;
        end
    endtask

    // Monitor: compare every pulse against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.vec_valid) begin
            logic [N*DW-1:0] e;
            logic [CW-1:0]   c;
            logic            dead;
            pulses++;
            pulse_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got data=%h count=%0d, required no pulse",
                         bus.vec_data, bus.vec_count);
            end else begin
                e = exp_q.pop_front();
                c = cnt_q.pop_front();
                if (bus.vec_data !== e) begin
                    miscompares++;
                    $display("FAIL frame_data: got %h, required %h", bus.vec_data, e);
                end
                vectors++;
                if (bus.vec_count !== c) begin
                    miscompares++;
                    $display("FAIL frame_count: got %0d, required %0d", bus.vec_count, c);
                end
            end
            dead = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (bus.vec_data[i*DW +: DW] == 16'hDEAD) dead = 1'b1;
            end
            vectors++;
            if (dead !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_data_leak: 0xDEAD found in %h, required absent", bus.vec_data);
            end
        end
    end

    // Driver: call at a falling edge; returns at the falling edge after the accepting edge.
    task automatic put(input logic [DW-1:0] d, input logic l, output int waited);
        int b;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        b = 0;
        while (!bus.s_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        waited = b;
        if (b >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL put_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, b);
        end else begin
            @(posedge clk);
            model_accept(d, l);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 16'hDEAD;
        bus.s_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (bus.vec_valid !== 1'b0 || bus.vec_count !== '0 || bus.vec_data !== '0 ||
            bus.s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got valid=%b count=%0d ready=%b data=%h, required all zero",
                     tag, bus.vec_valid, bus.vec_count, bus.s_ready, bus.vec_data);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'hDEAD;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, required 1", bus.s_ready);
        end
    endtask

    task automatic test_full_frame();
        int w;
        int wsum;
        wsum = 0;
        for (int i = 0; i < N; i++) begin
            put(16'(7 - i), 1'b0, w);
            wsum += w;
        end
        vectors++;
        if (wsum !== 0) begin
            miscompares++;
            $display("FAIL full_ready_stalls: got %0d stall cycles, required 0", wsum);
        end
        vectors++;
        if (bus.s_ready !== 1'b0 || bus.vec_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL emit_cycle: got ready=%b valid=%b, required ready=0 valid=1",
                     bus.s_ready, bus.vec_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.s_ready !== 1'b1 || bus.vec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_emit: got ready=%b valid=%b, required ready=1 valid=0",
                     bus.s_ready, bus.vec_valid);
        end
        vectors++;
        if (bus.vec_count !== CW'(8) || bus.vec_data[7*DW +: DW] !== 16'h0000) begin
            miscompares++;
            $display("FAIL hold_after_emit: got count=%0d slot7=%h, required 8 and 0000",
                     bus.vec_count, bus.vec_data[7*DW +: DW]);
        end
    endtask

    task automatic test_short_frame();
        int w;
        put(16'h0010, 1'b0, w);
        put(16'h0020, 1'b0, w);
        put(16'h0030, 1'b1, w);
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int w;
        put(16'h1234, 1'b1, w);
        put(16'hAAAA, 1'b0, w);
        put(16'hBBBB, 1'b1, w);
        @(negedge clk);
    endtask

    task automatic test_gapped();
        int w;
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, N);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                put(16'($urandom_range(0, 16'hDEAC)), (i == len - 1), w);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int p0;
        for (int i = 0; i < 5; i++) put(16'(100 + i), 1'b0, w);
        p0 = pulses;
        rst_n = 1'b0;
        mdl_idx = 0;
        #1;
        check_reset_outputs("reset_mid_frame");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (pulses !== p0) begin
            miscompares++;
            $display("FAIL aborted_frame_pulse: got %0d pulses, required %0d", pulses, p0);
        end
        for (int i = 0; i < N; i++) put(16'(i), 1'b0, w);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w;
        int p0;
        p0 = pulses;
        pulse_cyc.delete();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) put(16'(f * 16 + i + 1), 1'b0, w);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (pulses - p0 !== 3) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d, required 3", pulses - p0);
        end
        if (pulse_cyc.size() == 3) begin
            vectors++;
            if (pulse_cyc[1] - pulse_cyc[0] !== 9 || pulse_cyc[2] - pulse_cyc[1] !== 9) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d and %0d cycles, required 9 and 9",
                         pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1]);
            end
        end
    endtask

    initial begin
        cyc         = 0;
        pulses      = 0;
        vectors     = 0;
        miscompares = 0;
        mdl_idx     = 0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_single_frame();
        test_gapped();
        test_reset_mid_frame();
        test_back_to_back();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL missing_frames: got %0d frames outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
